// File: rtl/axil_cmd_master.sv
// AXI4-Lite command master: queues {write, addr, data, strb} commands and issues them
// in order as single-beat AXI4-Lite transactions, with at most one outstanding at a time.
module axil_cmd_master #(
    parameter int CMD_DEPTH = 4
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,

    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,

    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY
);
    localparam int PW = $clog2(CMD_DEPTH);

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP} state_t;

    cmd_t        mem [CMD_DEPTH];
    cmd_t        head;
    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    state_t      state;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign head      = mem[rd_ptr[PW-1:0]];
    assign busy      = !empty || (state != IDLE);

    // NOTE: the storage array has no reset; entries are only read once the pointers cover them.
    always_ff @(posedge M_AXI_ACLK) begin
        if (push) begin
            mem[wr_ptr[PW-1:0]] <= '{write: cmd_write, addr: cmd_addr, data: cmd_data, strb: cmd_strb};
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{PW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{PW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state         <= IDLE;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WDATA   <= '0;
            M_AXI_WSTRB   <= '0;
            M_AXI_WVALID  <= 1'b0;
            M_AXI_BREADY  <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_data      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head.write) begin
                            M_AXI_AWADDR  <= head.addr;
                            M_AXI_WDATA   <= head.data;
                            M_AXI_WSTRB   <= head.strb;
                            M_AXI_AWVALID <= 1'b1;
                            M_AXI_WVALID  <= 1'b1;
                            state         <= WADDR;
                        end else begin
                            M_AXI_ARADDR  <= head.addr;
                            M_AXI_ARVALID <= 1'b1;
                            state         <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    // AW and W complete independently; leave once neither is still pending.
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state        <= WRESP;
                    end
                end
                WRESP: begin
                    if (M_AXI_BVALID) begin
                        M_AXI_BREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_data     <= '0;
                        rsp_err      <= |M_AXI_BRESP;
                        state        <= IDLE;
                    end
                end
                RADDR: begin
                    if (M_AXI_ARREADY) begin
                        M_AXI_ARVALID <= 1'b0;
                        M_AXI_RREADY  <= 1'b1;
                        state         <= RRESP;
                    end
                end
                RRESP: begin
                    if (M_AXI_RVALID) begin
                        M_AXI_RREADY <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_data     <= M_AXI_RDATA;
                        rsp_err      <= |M_AXI_RRESP;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
